// File: rtl/educore_mem_responder.sv
// Unified instruction/data memory responder for the Educore core: program-load port,
// core reset sequencing, byte-addressed fetch/load/store service and halt on yield/undefined.
module educore_mem_responder #(
  parameter int          ADDR_W     = 16,
  parameter int          RESET_HOLD = 6,
  parameter logic [3:0]  YIELD_CODE = 4'h1,
  parameter logic [3:0]  UNDEF_CODE = 4'h2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              instruction_memory_en,
  input  logic [63:0]       instruction_memory_a,
  output logic [31:0]       instruction_memory_v,
  input  logic [63:0]       data_memory_a,
  input  logic [1:0]        data_memory_s,
  input  logic              data_memory_read,
  input  logic              data_memory_write,
  input  logic [63:0]       data_memory_out_v,
  output logic [63:0]       data_memory_in_v,
  input  logic [3:0]        error_indicator,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              load_done,
  output logic              core_nreset,
  output logic              halted,
  output logic [1:0]        halt_cause
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_YIELD = 2'b01;
  localparam logic [1:0] CAUSE_UNDEF = 2'b10;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e             r_state, w_state_next;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_next;
  logic [1:0]         r_halt_cause, w_halt_cause_next;
  logic               r_core_nreset;
  logic               r_load_ready;
  logic               r_halted;
  logic [31:0]        r_fetch_word;
  logic [63:0]        r_data_word;

  logic [7:0]         r_mem [DEPTH];

  logic [ADDR_W-1:0]  w_ia;
  logic [ADDR_W-1:0]  w_da;
  logic [31:0]        w_fetch_word;
  logic [63:0]        w_data_word;
  logic               w_run;
  logic               w_load_we;
  logic               w_store_en;
  logic [7:0]         w_store_be;
  logic               w_unused;

  assign w_ia = instruction_memory_a[ADDR_W-1:0];
  assign w_da = data_memory_a[ADDR_W-1:0];
  assign w_unused = ^{instruction_memory_a[63:ADDR_W], data_memory_a[63:ADDR_W]};

  assign w_run      = (r_state == ST_RUN);
  assign w_load_we  = (r_state == ST_LOAD) && load_valid && r_load_ready;
  assign w_store_en = w_run && data_memory_write;

  // Byte addresses wrap naturally because every offset is added at ADDR_W width.
  always_comb begin
    w_fetch_word = '0;
    w_data_word  = '0;
    for (int k = 0; k < 4; k++) begin
      w_fetch_word[8*k +: 8] = r_mem[w_ia + ADDR_W'(k)];
    end
    for (int k = 0; k < 8; k++) begin
      w_data_word[8*k +: 8] = r_mem[w_da + ADDR_W'(k)];
    end
  end

  always_comb begin
    w_store_be = 8'h00;
    case (data_memory_s)
      2'b00:   w_store_be = 8'h01;
      2'b01:   w_store_be = 8'h03;
      2'b10:   w_store_be = 8'h0F;
      default: w_store_be = 8'hFF;
    endcase
  end

  // NOTE: the storage array has no reset branch; clearing a RAM on reset is not
  // possible in real memory and contents must survive nreset anyway.
  always_ff @(posedge clk) begin
    if (w_load_we) begin
      r_mem[load_addr] <= load_data;
    end
    for (int k = 0; k < 8; k++) begin
      if (w_store_en && w_store_be[k]) begin
        r_mem[w_da + ADDR_W'(k)] <= data_memory_out_v[8*k +: 8];
      end
    end
  end

  // NOTE: every variable gets a default first so no path through the case leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next      = r_state;
    w_hold_cnt_next   = r_hold_cnt;
    w_halt_cause_next = r_halt_cause;
    case (r_state)
      ST_LOAD: begin
        w_hold_cnt_next = '0;
        if (load_done) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_hold_cnt == CNT_W'(RESET_HOLD - 1)) begin
          w_state_next    = ST_RUN;
          w_hold_cnt_next = '0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (error_indicator == YIELD_CODE) begin
          w_state_next      = ST_HALT;
          w_halt_cause_next = CAUSE_YIELD;
        end else if (error_indicator == UNDEF_CODE) begin
          w_state_next      = ST_HALT;
          w_halt_cause_next = CAUSE_UNDEF;
        end
      end
      default: w_state_next = ST_HALT;
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples values from before the clock edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= ST_LOAD;
      r_hold_cnt    <= '0;
      r_halt_cause  <= CAUSE_NONE;
      r_core_nreset <= 1'b0;
      r_load_ready  <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_word  <= '0;
      r_data_word   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_hold_cnt    <= w_hold_cnt_next;
      r_halt_cause  <= w_halt_cause_next;
      r_core_nreset <= (w_state_next == ST_RUN) || (w_state_next == ST_HALT);
      r_load_ready  <= (w_state_next == ST_LOAD);
      r_halted      <= (w_state_next == ST_HALT);
      // Reads see the array before this edge's store lands, giving read-old behaviour.
      if (w_run && instruction_memory_en) r_fetch_word <= w_fetch_word;
      if (w_run && data_memory_read)      r_data_word  <= w_data_word;
    end
  end

  assign instruction_memory_v = r_fetch_word;
  assign data_memory_in_v     = r_data_word;
  assign load_ready           = r_load_ready;
  assign core_nreset          = r_core_nreset;
  assign halted               = r_halted;
  assign halt_cause           = r_halt_cause;

endmodule

// File: tb/tb_educore_mem_responder.sv
// Directed bench for educore_mem_responder: program load, reset hold, fetch/load/store,
// address wrap, read-old ordering, halt behaviour and memory retention across reset.
module tb_educore_mem_responder;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              nreset;
  logic              instruction_memory_en;
  logic [63:0]       instruction_memory_a;
  logic [31:0]       instruction_memory_v;
  logic [63:0]       data_memory_a;
  logic [1:0]        data_memory_s;
  logic              data_memory_read;
  logic              data_memory_write;
  logic [63:0]       data_memory_out_v;
  logic [63:0]       data_memory_in_v;
  logic [3:0]        error_indicator;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_done;
  logic              core_nreset;
  logic              halted;
  logic [1:0]        halt_cause;

  int n_vec = 0;
  int n_err = 0;

  educore_mem_responder #(
    .ADDR_W(ADDR_W), .RESET_HOLD(6), .YIELD_CODE(4'h1), .UNDEF_CODE(4'h2)
  ) dut (
    .clk(clk), .nreset(nreset),
    .instruction_memory_en(instruction_memory_en),
    .instruction_memory_a(instruction_memory_a),
    .instruction_memory_v(instruction_memory_v),
    .data_memory_a(data_memory_a), .data_memory_s(data_memory_s),
    .data_memory_read(data_memory_read), .data_memory_write(data_memory_write),
    .data_memory_out_v(data_memory_out_v), .data_memory_in_v(data_memory_in_v),
    .error_indicator(error_indicator),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .core_nreset(core_nreset), .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [15:0] a, input logic [7:0] d, input logic done);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_done  = done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  // Expects load_done to have just been sampled; core_nreset rises on the 6th edge after it.
  task automatic hold_sequence(input string tag);
    check({tag, "_nrst_e0"}, 64'(core_nreset), 64'd0);
    check({tag, "_ready_hold"}, 64'(load_ready), 64'd0);
    for (int i = 1; i < 6; i++) begin
      tick();
      check($sformatf("%s_nrst_e%0d", tag, i), 64'(core_nreset), 64'd0);
    end
    tick();
    check({tag, "_nrst_e6"}, 64'(core_nreset), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    nreset = 1'b0;
    #2;
    check({tag, "_nrst"}, 64'(core_nreset), 64'd0);
    check({tag, "_ready"}, 64'(load_ready), 64'd0);
    check({tag, "_halted"}, 64'(halted), 64'd0);
    check({tag, "_cause"}, 64'(halt_cause), 64'd0);
    check({tag, "_imv"}, 64'(instruction_memory_v), 64'd0);
    check({tag, "_dmv"}, data_memory_in_v, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    tick();
    check({tag, "_ready_rel"}, 64'(load_ready), 64'd1);
  endtask

  task automatic reload_only(input string tag);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    hold_sequence(tag);
  endtask

  initial begin
    nreset = 1'b0;
    instruction_memory_en = 1'b0; instruction_memory_a = '0;
    data_memory_a = '0; data_memory_s = 2'b00;
    data_memory_read = 1'b0; data_memory_write = 1'b0; data_memory_out_v = '0;
    error_indicator = 4'h0;
    load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;

    // Power-on reset, held across one edge
    do_reset("por");

    // Program image; the final byte shares its cycle with load_done
    load_byte(16'h0104, 8'hA0, 1'b0);
    load_byte(16'h0105, 8'hA1, 1'b0);
    load_byte(16'h0106, 8'hA2, 1'b0);
    load_byte(16'h0107, 8'hA3, 1'b0);
    for (int i = 0; i < 8; i++) load_byte(16'h0200 + 16'(i), 8'h00, 1'b0);
    load_byte(16'h0100, 8'hDE, 1'b0);
    load_byte(16'h0101, 8'hAD, 1'b0);
    load_byte(16'h0102, 8'hBE, 1'b0);
    load_byte(16'h0103, 8'hEF, 1'b1);
    hold_sequence("hold1");

    // Fetch
    instruction_memory_en = 1'b1; instruction_memory_a = 64'h100;
    tick();
    instruction_memory_en = 1'b0;
    check("fetch_100", 64'(instruction_memory_v), 64'hEFBEADDE);

    // Halfword store, then read back: bytes 0x106/0x107 untouched
    data_memory_write = 1'b1; data_memory_a = 64'h104; data_memory_s = 2'b01;
    data_memory_out_v = 64'h1122334455667788;
    tick();
    data_memory_write = 1'b0;
    data_memory_read = 1'b1;
    tick();
    data_memory_read = 1'b0;
    check("st16_rd", 64'(data_memory_in_v[31:0]), 64'hA3A27788);

    // Simultaneous doubleword write and read: read-old, then new
    data_memory_write = 1'b1; data_memory_read = 1'b1; data_memory_a = 64'h200;
    data_memory_s = 2'b11; data_memory_out_v = 64'hCAFEBABE12345678;
    tick();
    data_memory_write = 1'b0;
    check("rw_same_old", data_memory_in_v, 64'h0);
    tick();
    data_memory_read = 1'b0;
    check("rw_next_new", data_memory_in_v, 64'hCAFEBABE12345678);

    // Wrapping doubleword store at the top of the address space
    data_memory_write = 1'b1; data_memory_a = 64'hFFFC; data_memory_s = 2'b11;
    data_memory_out_v = 64'h0807060504030201;
    tick();
    data_memory_write = 1'b0;
    data_memory_read = 1'b1; data_memory_a = 64'hABCD_0000_0000_FFFC;
    instruction_memory_en = 1'b1; instruction_memory_a = 64'h8000_0000_0000_FFFE;
    tick();
    instruction_memory_en = 1'b0;
    check("wrap_rd_fffc", data_memory_in_v, 64'h0807060504030201);
    check("wrap_fetch_fffe", 64'(instruction_memory_v), 64'h06050403);
    data_memory_a = 64'h0;
    tick();
    data_memory_read = 1'b0;
    check("wrap_rd_0000", 64'(data_memory_in_v[31:0]), 64'h08070605);

    // Reset mid-RUN; memory survives a load_done-only reload
    do_reset("rst2");
    reload_only("hold2");
    load_valid = 1'b1; load_addr = 16'h0104; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    data_memory_read = 1'b1; data_memory_a = 64'h104;
    tick();
    check("keep_104", 64'(data_memory_in_v[31:0]), 64'hA3A27788);
    data_memory_a = 64'hFFFC;
    instruction_memory_en = 1'b1; instruction_memory_a = 64'h100;
    tick();
    data_memory_read = 1'b0; instruction_memory_en = 1'b0;
    check("keep_fffc", data_memory_in_v, 64'h0807060504030201);
    check("keep_fetch", 64'(instruction_memory_v), 64'hEFBEADDE);

    // Yield: same-cycle read still serviced, then writes suppressed and reads frozen
    error_indicator = 4'h1; data_memory_read = 1'b1; data_memory_a = 64'h200;
    tick();
    error_indicator = 4'h0;
    check("yield_halted", 64'(halted), 64'd1);
    check("yield_cause", 64'(halt_cause), 64'h1);
    check("yield_nrst", 64'(core_nreset), 64'd1);
    check("yield_last_rd", data_memory_in_v, 64'hCAFEBABE12345678);
    data_memory_write = 1'b1; data_memory_a = 64'h104; data_memory_s = 2'b10;
    data_memory_out_v = 64'hFFFF_FFFF_FFFF_FFFF;
    instruction_memory_en = 1'b1; instruction_memory_a = 64'hFFFE;
    tick();
    data_memory_write = 1'b0; data_memory_read = 1'b0; instruction_memory_en = 1'b0;
    check("halt_dmv_frozen", data_memory_in_v, 64'hCAFEBABE12345678);
    check("halt_imv_frozen", 64'(instruction_memory_v), 64'hEFBEADDE);
    check("halt_stays", 64'(halted), 64'd1);

    // Halted write must not have landed
    do_reset("rst3");
    reload_only("hold3");
    data_memory_read = 1'b1; data_memory_a = 64'h104;
    tick();
    data_memory_read = 1'b0;
    check("halt_no_write", 64'(data_memory_in_v[31:0]), 64'hA3A27788);

    // Undefined instruction
    error_indicator = 4'h2;
    tick();
    error_indicator = 4'h0;
    check("undef_halted", 64'(halted), 64'd1);
    check("undef_cause", 64'(halt_cause), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/educore_mem_responder.md
Name: educore_mem_responder

Overview:
- Synthesizable unified instruction/data memory responder for Educore, sitting on the core side of the instruction and data memory ports.
- Owns a byte-addressed store and a program-load port.
- Holds the core in reset during load, releases it after a fixed hold, then services fetches, loads and stores.
- Freezes the core when the core reports yield or undefined.

Parameters:
ADDR_W, 16, byte-address bits used; memory depth is 2**ADDR_W bytes; upper address bits ignored
RESET_HOLD, 6, clk cycles core_nreset stays low after load_done
YIELD_CODE, 4'h1, error_indicator value meaning yield (must equal `ERROR_YIELD)
UNDEF_CODE, 4'h2, error_indicator value meaning undefined instruction (must equal `ERROR_UNDEFINED)

Ports:
clk  input  1  single clock; all logic on posedge
nreset  input  1  asynchronous active-low reset
instruction_memory_en  input  1  fetch enable
instruction_memory_a  input  64  fetch byte address
instruction_memory_v  output  32  fetched word, little-endian
data_memory_a  input  64  data byte address
data_memory_s  input  2  size: 00=1B, 01=2B, 10=4B, 11=8B
data_memory_read  input  1  data read strobe
data_memory_write  input  1  data write strobe
data_memory_out_v  input  64  store data from core
data_memory_in_v  output  64  load data to core, little-endian
error_indicator  input  4  core status
load_valid  input  1  loader byte valid
load_ready  output  1  loader may present a byte
load_addr  input  ADDR_W  loader byte address
load_data  input  8  loader byte
load_done  input  1  end of program image (pulse)
core_nreset  output  1  reset to Educore, active low
halted  output  1  1 = core stopped (yield or undefined)
halt_cause  output  2  00 none, 01 yield, 10 undefined

Behaviour:
- States: LOAD, HOLD, RUN, HALT.
- Reset (nreset=0, async):
  - state=LOAD; core_nreset=0; halted=0; halt_cause=00.
  - instruction_memory_v=0; data_memory_in_v=0; load_ready=0 until the first clk after reset deasserts, then 1.
  - Hold counter cleared. Memory contents are not cleared.
- LOAD:
  - load_ready=1.
  - load_valid & load_ready writes load_data to mem[load_addr] at posedge.
  - Core ports are ignored.
  - load_done -> HOLD. A byte presented in the same cycle as load_done is still written.
- HOLD:
  - load_ready=0; core_nreset=0.
  - Counter runs 0..RESET_HOLD-1, then -> RUN.
  - core_nreset=1 from the first RUN cycle (registered output).
- RUN:
  - Fetch: if instruction_memory_en at posedge, instruction_memory_v <= {mem[a+3],mem[a+2],mem[a+1],mem[a]}; otherwise it holds. Latency 1 cycle.
  - Load: if data_memory_read, data_memory_in_v <= 8 bytes mem[a..a+7] regardless of size; the core masks the result. Otherwise it holds.
  - Store: if data_memory_write, write bytes per size:
    - s=00: byte 0.
    - s=01: bytes 0-1.
    - s=10: bytes 0-3.
    - s=11: bytes 0-7.
    - Byte k = data_memory_out_v[8k+7:8k] goes to mem[a+k].
  - Addresses use a[ADDR_W-1:0]; a+k wraps modulo 2**ADDR_W. No alignment check.
  - Read and write to overlapping bytes in the same cycle: reads return pre-write data (read-old). This applies to both fetch and data read.
  - Read and write strobes both high: both performed.
  - error_indicator==YIELD_CODE at posedge -> HALT, halt_cause=01.
  - error_indicator==UNDEF_CODE at posedge -> HALT, halt_cause=10.
  - The transition is registered; the access in that same cycle is still serviced.
- HALT:
  - halted=1; core_nreset=1.
  - Writes suppressed; read outputs frozen.
  - Stays until nreset.
- Async reset mid-RUN or mid-LOAD: immediate return to LOAD, outputs as above, memory preserved.
- load_valid outside LOAD is ignored.

Test Plan:
- Load 0xDE@0x0100, 0xAD@0x0101, 0xBE@0x0102, 0xEF@0x0103, then load_done -> core_nreset low exactly 6 cycles after the load_done edge, then 1; fetch a=0x100 -> instruction_memory_v=0xEFBEADDE one cycle later.
- In RUN, write a=0x104, s=01, out_v=0x1122334455667788 -> mem[0x104]=0x88, mem[0x105]=0x77, mem[0x106] unchanged; read a=0x104 next cycle -> data_memory_in_v[15:0]=0x7788.
- Same cycle: write s=11 to 0x200 and read 0x200 (old all-zero contents) -> data_memory_in_v=0; a read on the following cycle returns the new value.
- Write s=11 at a=0xFFFC with 0x0807060504030201 -> mem[0xFFFC..0xFFFF]=01..04, mem[0x0000..0x0003]=05..08 (wrap).
- error_indicator=YIELD_CODE in RUN -> next cycle halted=1, halt_cause=01; a subsequent data_memory_write leaves memory unchanged.
- Assert nreset low mid-RUN -> core_nreset=0, load_ready=1 after release; previously written bytes are still readable after reload with load_done only.
